// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer driving one external round core.
// Optional abort input is enabled by defining AES_CTRL_ABORT_EN.
module aes_subword (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    // S-box as GF(2^8) inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] v;
        p = a;
        v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            v = gmul(v, p);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction
    for (genvar g = 0; g < 4; g++) begin : g_sb
        assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
    end
endmodule

module aes_round_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [127:0] core_din,
    output logic [127:0] core_kin,
    output logic         core_sel,
    input  logic [127:0] core_dout
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    localparam logic [3:0] LAST = 4'(ROUNDS);
    fsm_t         r_fsm;
    fsm_t         w_fsm_nxt;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;
    logic [7:0]   r_rcon;
    logic         w_accept;
    logic         w_deliver;
    logic         w_abort;
    logic         w_last;
    logic [31:0]  w_sub;
    logic [31:0]  w_k0;
    logic [31:0]  w_k1;
    logic [31:0]  w_k2;
    logic [31:0]  w_k3;
    assign w_accept  = r_fsm == IDLE && in_valid;
    assign w_deliver = r_fsm == DONE && out_ready;
    assign w_last    = r_rnd == LAST;
`ifdef AES_CTRL_ABORT_EN
    assign w_abort = abort && r_fsm != IDLE;
`else
    assign w_abort = 1'b0;
`endif
    assign in_ready  = r_fsm == IDLE;
    assign out_valid = r_fsm == DONE;
    assign busy      = r_fsm != IDLE;
    assign out_data  = r_state;
    assign core_din  = r_state;
    assign core_sel  = r_fsm == RUN && w_last;
    // key path owns its S-boxes so the round core stays single-use
    aes_subword u_sub (
        .i_word ({r_key[23:0], r_key[31:24]}),
        .o_word (w_sub)
    );
    assign w_k0     = r_key[127:96] ^ w_sub ^ {r_rcon, 24'h0};
    assign w_k1     = r_key[95:64] ^ w_k0;
    assign w_k2     = r_key[63:32] ^ w_k1;
    assign w_k3     = r_key[31:0] ^ w_k2;
    assign core_kin = {w_k0, w_k1, w_k2, w_k3};
    // state register for the sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= IDLE;
        else r_fsm <= w_fsm_nxt;
    end
    // next state: abort beats everything, including a same-edge delivery
    always_comb begin
        w_fsm_nxt = r_fsm;
        if (w_abort) w_fsm_nxt = IDLE;
        else if (w_accept) w_fsm_nxt = RUN;
        else if (r_fsm == RUN && w_last) w_fsm_nxt = DONE;
        else if (w_deliver) w_fsm_nxt = IDLE;
    end
    // block state, round key, round counter and rcon; core result is stored un-inverted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_rnd   <= '0;
            r_rcon  <= 8'h01;
        end else if (w_abort) begin
            r_state <= '0;
            r_key   <= '0;
            r_rnd   <= '0;
            r_rcon  <= 8'h01;
        end else if (w_accept) begin
            r_state <= in_data ^ in_key;
            r_key   <= in_key;
            r_rnd   <= 4'd1;
            r_rcon  <= 8'h01;
        end else if (r_fsm == RUN) begin
            r_state <= ~core_dout;
            r_key   <= core_kin;
            r_rnd   <= w_last ? r_rnd : r_rnd + 4'd1;
            r_rcon  <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench with a behavioural round core and a ciphertext scoreboard.
module tb_aes_round_ctrl;
    localparam int ROUNDS = 10;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic         core_sel;
    logic [127:0] out_data;
    logic [127:0] core_din;
    logic [127:0] core_kin;
    logic [127:0] core_dout;
`ifdef AES_CTRL_ABORT_EN
    logic         abort = 1'b0;
`endif
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           n_hs = 0;
    logic [127:0] exp_ct = '0;
    logic [127:0] sbq[$];
    int           acc_t[$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .core_din  (core_din),
        .core_kin  (core_kin),
        .core_sel  (core_sel),
        .core_dout (core_dout)
`ifdef AES_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    function automatic logic [7:0] sb_lut(input logic [7:0] v);
        return SBOX[2047 - 8*int'(v) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // reference round core: SubBytes, ShiftRows, MixColumns unless s, AddRoundKey, inverted
    function automatic logic [127:0] core_model(input logic [127:0] d, input logic [127:0] k, input logic s);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sb_lut(d[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) b[j + 4*c] = a[j + 4*((c + j) % 4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
            m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s ? b[i] : m[i];
        return ~(r ^ k);
    endfunction

    assign core_dout = core_model(core_din, core_kin, core_sel);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: pops/compares on an output handshake, pushes the expectation on an accept
    task automatic step();
        logic acc;
        logic hs;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (hs) begin
            n_hs++;
            check("sb_nonempty", 128'(sbq.size() != 0), 128'd1);
            if (sbq.size() != 0) check("ciphertext", out_data, sbq.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            sbq.push_back(exp_ct);
            acc_t.push_back(cyc);
        end
    endtask

    task automatic offer(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
        in_data  = pt;
        in_key   = key;
        exp_ct   = ct;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            step();
            n++;
        end
        check("out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    initial begin
        int  n;
        int  hs0;
        logic stable;
        logic [127:0] held;
        #1 rst = 1'b1;
        #3;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_core_sel", 128'(core_sel), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        // FIPS-197 C.1 with latency measured from the accept edge
        out_ready = 1'b1;
        offer(C1_PT, C1_KEY, C1_CT);
        check("c1_busy", 128'(busy), 128'd1);
        check("c1_in_ready_run", 128'(in_ready), 128'd0);
        wait_valid(40, n);
        check("c1_edges_incl_accept", 128'(n + 1), 128'(ROUNDS + 1));
        step();
        check("c1_in_ready_after", 128'(in_ready), 128'd1);
        check("c1_out_valid_after", 128'(out_valid), 128'd0);
        // FIPS-197 App. B: final-round select and last two round keys
        offer(B_PT, B_KEY, B_CT);
        for (int i = 1; i <= ROUNDS; i++) begin
            check($sformatf("b_core_sel_r%0d", i), 128'(core_sel), 128'(i == ROUNDS));
            if (i == 9) check("b_rk9", core_kin, B_RK9);
            if (i == 10) check("b_rk10", core_kin, B_RK10);
            step();
        end
        check("b_out_valid", 128'(out_valid), 128'd1);
        step();
        // backpressure: result must hold and in_valid pulses must be ignored
        out_ready = 1'b0;
        offer(C1_PT, C1_KEY, C1_CT);
        wait_valid(40, n);
        held   = out_data;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            exp_ct   = '1;
            step();
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", 128'(stable), 128'd1);
        check("bp_held_value", held, C1_CT);
        hs0 = n_hs;
        out_ready = 1'b1;
        step();
        check("bp_one_transfer", 128'(n_hs - hs0), 128'd1);
        check("bp_in_ready_next", 128'(in_ready), 128'd1);
        check("bp_sb_empty", 128'(sbq.size()), 128'd0);
        // back-to-back: two vectors offered continuously
        acc_t.delete();
        hs0      = n_hs;
        in_data  = C1_PT;
        in_key   = C1_KEY;
        exp_ct   = C1_CT;
        in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (acc_t.size() == 1) begin
                in_data = B_PT;
                in_key  = B_KEY;
                exp_ct  = B_CT;
            end else if (acc_t.size() == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 128'(acc_t.size()), 128'd2);
        if (acc_t.size() == 2) check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'(ROUNDS + 2));
        check("b2b_transfers", 128'(n_hs - hs0), 128'd2);
        // asynchronous reset in round 5
        offer(C1_PT, C1_KEY, C1_CT);
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check("mid_rst_out_data", out_data, 128'd0);
        check("mid_rst_core_sel", 128'(core_sel), 128'd0);
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        hs0 = n_hs;
        repeat (12) step();
        check("mid_rst_no_output", 128'(n_hs - hs0), 128'd0);
        offer(C1_PT, C1_KEY, C1_CT);
        wait_valid(40, n);
        step();
        check("mid_rst_recovered", 128'(n_hs - hs0), 128'd1);
`ifdef AES_CTRL_ABORT_EN
        // abort in round 3
        offer(C1_PT, C1_KEY, C1_CT);
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        sbq.delete();
        check("abort_run_busy", 128'(busy), 128'd0);
        check("abort_run_out_valid", 128'(out_valid), 128'd0);
        check("abort_run_state", out_data, 128'd0);
        // abort on the same edge as the output handshake
        offer(B_PT, B_KEY, B_CT);
        wait_valid(40, n);
        hs0   = n_hs;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        sbq.delete();
        check("abort_done_out_valid", 128'(out_valid), 128'd0);
        check("abort_done_state", out_data, 128'd0);
        check("abort_done_in_ready", 128'(in_ready), 128'd1);
        offer(B_PT, B_KEY, B_CT);
        wait_valid(40, n);
        step();
        check("abort_recovered", 128'(n_hs - hs0), 128'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
